gf2m_reduce_seq: RTL



---
 rtl/gf2m_reduce_seq.sv | 116 +++++++++++
 1 files changed

// File: rtl/gf2m_reduce_seq.sv
// Sequential GF(2^M) reduction of a (2M-1)-bit carry-less product modulo POLY, STEP bits per cycle.
// Optional early exit when the upper half is already clear: define GF2M_REDUCE_EARLY_EXIT_EN.
module gf2m_reduce_seq #(
  parameter int          M    = 24,
  parameter logic [M:0]  POLY = 25'h100001B,
  parameter int          STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*M-2:0]   in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     out_res
);
  localparam int PW  = 2*M-1;
  localparam int NIT = (M-1+STEP-1)/STEP;
  localparam int CW  = $clog2(NIT+1);
  localparam logic [PW-1:0] POLY_EXT = PW'(POLY);
  localparam logic [PW-1:0] ONE_EXT  = PW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg;
  logic [PW-1:0]   r_reg;
  logic [PW-1:0]   r_next;
  logic [CW-1:0]   cnt_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic [M-1:0]    out_res_reg;
  logic            run_last;

  // One window of STEP bits per cycle; each stage sees the XORs of the stages above it.
  logic [PW-1:0] chain [0:STEP];
  assign chain[0] = r_reg;

  for (genvar gi = 0; gi < STEP; gi++) begin : g_chain
    int   bit_idx;
    logic hit;
    assign bit_idx = PW - 1 - gi - int'(cnt_reg) * STEP;
    assign hit     = (bit_idx >= M) && (|(chain[gi] & (ONE_EXT << bit_idx)));
    assign chain[gi+1] = hit ? (chain[gi] ^ (POLY_EXT << (bit_idx - M))) : chain[gi];
  end

  assign r_next = chain[STEP];

`ifdef GF2M_REDUCE_EARLY_EXIT_EN
  logic top_clear;
  logic prod_small;
  assign top_clear  = ~|r_next[PW-1:M];
  assign prod_small = ~|in_prod[PW-1:M];
  assign run_last   = (cnt_reg == CW'(NIT-1)) || top_clear;
`else
  assign run_last   = (cnt_reg == CW'(NIT-1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      r_reg         <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_res_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            r_reg        <= in_prod;
            out_res_reg  <= in_prod[M-1:0];
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
`ifdef GF2M_REDUCE_EARLY_EXIT_EN
            if (prod_small) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end else begin
              state_reg     <= RUN;
            end
`else
            state_reg    <= RUN;
`endif
          end
        end
        RUN: begin
          r_reg       <= r_next;
          out_res_reg <= r_next[M-1:0];
          cnt_reg     <= cnt_reg + CW'(1);
          if (run_last) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          // Release only; a new product is accepted one cycle later from IDLE.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_res   = out_res_reg;

endmodule
